kbd_ctrl: RTL and testbench

KBD_CTRL -- requirements
Module: kbd_ctrl

---
 rtl/kbd_ctrl.sv | 154 +++++++++++++++
 tb/tb_kbd_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : kbd_ctrl
// Brief   : PS/2 keyboard receiver feeding a show-ahead scan-code FIFO.
//           Define KBD_PARITY_CHK_EN to reject frames failing odd parity.
// Revision: 1.0 - initial release
// ============================================================================
module kbd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int KbWidth    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               sig_rd_kb,
    output logic [KbWidth-1:0] kb_rdata,
    output logic               kb_ready,
    output logic               overflow,
    output logic               frame_err
);
    localparam int         c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] c_PAR_CNT  = 4'(KbWidth + 1);
    localparam logic [3:0] c_STOP_CNT = 4'(KbWidth + 2);
    localparam logic [c_AW:0] c_PTR_ONE = 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RECV = 1'b1} state_t;

    logic               r_clk_s1, r_clk_s2, r_clk_prev;
    logic               r_data_s1, r_data_s2;
    logic               r_sync_live, r_clk_seen_hi;
    state_t             r_state;
    logic [3:0]         r_bit_cnt;
    logic [KbWidth-1:0] r_shift;
`ifdef KBD_PARITY_CHK_EN
    logic               r_parity;
`endif
    logic               r_frame_err, r_overflow;
    logic [KbWidth-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]      r_wr_ptr, r_rd_ptr;

    logic w_sample, w_stop, w_par_ok, w_valid, w_push, w_pop, w_empty, w_full, w_wr_en;

    // A falling edge only counts once the real pin has been seen high after
    // reset, so a low level held across reset release is not taken as a sample.
    assign w_sample = ~r_clk_s2 & r_clk_prev & r_clk_seen_hi;
    assign w_stop   = w_sample && (r_state == S_RECV) && (r_bit_cnt == c_STOP_CNT);
`ifdef KBD_PARITY_CHK_EN
    assign w_par_ok = ^{r_shift, r_parity};
`else
    assign w_par_ok = 1'b1;
`endif
    assign w_valid  = r_data_s2 & w_par_ok;
    assign w_push   = w_stop & w_valid;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop    = sig_rd_kb & ~w_empty;
    assign w_wr_en  = w_push & (~w_full | w_pop);

    assign kb_ready  = ~w_empty;
    assign kb_rdata  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_s1      <= 1'b1;
            r_clk_s2      <= 1'b1;
            r_clk_prev    <= 1'b1;
            r_data_s1     <= 1'b1;
            r_data_s2     <= 1'b1;
            r_sync_live   <= 1'b0;
            r_clk_seen_hi <= 1'b0;
        end else begin
            r_clk_s1    <= ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_clk_prev  <= r_clk_s2;
            r_data_s1   <= ps2_data;
            r_data_s2   <= r_data_s1;
            r_sync_live <= 1'b1;
            if (r_sync_live && r_clk_s1) begin
                r_clk_seen_hi <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= '0;
`ifdef KBD_PARITY_CHK_EN
            r_parity    <= 1'b0;
`endif
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_stop & ~w_valid;
            if (w_sample) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_data_s2) begin
                            r_state   <= S_RECV;
                            r_bit_cnt <= 4'd1;
                        end
                    end
                    S_RECV: begin
                        if (r_bit_cnt == c_STOP_CNT) begin
                            r_state   <= S_IDLE;
                            r_bit_cnt <= 4'd0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt < c_PAR_CNT) begin
                                r_shift <= {r_data_s2, r_shift[KbWidth-1:1]};
                            end
`ifdef KBD_PARITY_CHK_EN
                            if (r_bit_cnt == c_PAR_CNT) begin
                                r_parity <= r_data_s2;
                            end
`endif
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_kbd_ctrl
// Brief   : Directed and randomised PS/2 frames checked against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_kbd_ctrl;
    localparam int c_DEPTH = 8;
    localparam int c_W     = 8;
`ifdef KBD_PARITY_CHK_EN
    localparam bit c_PAR_EN = 1'b1;
`else
    localparam bit c_PAR_EN = 1'b0;
`endif

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           ps2_clk   = 1'b1;
    logic           ps2_data  = 1'b1;
    logic           sig_rd_kb = 1'b0;
    logic [c_W-1:0] kb_rdata;
    logic           kb_ready;
    logic           overflow;
    logic           frame_err;

    always #5 clk = ~clk;

    kbd_ctrl #(.FIFO_DEPTH(c_DEPTH), .KbWidth(c_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .sig_rd_kb (sig_rd_kb),
        .kb_rdata  (kb_rdata),
        .kb_ready  (kb_ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    logic [7:0] m_q [$];
    logic       m_ovf = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_head();
        if (m_q.size() == 0) return 32'd0;
        return {24'd0, m_q[0]};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one bit and the falling edge; returns inside the sample cycle.
    task automatic ps2_fall(input logic b);
        ps2_data = b;
        step(4);
        ps2_clk = 1'b0;
        step(2);
    endtask

    task automatic ps2_rise();
        step(4);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit pop_at_stop);
        logic [10:0] bits;
        bit          valid;
        bits[0]    = 1'b0;
        bits[8:1]  = d;
        bits[9]    = ~(^d) ^ bad_par;
        bits[10]   = ~bad_stop;
        for (int i = 0; i < 10; i++) begin
            ps2_fall(bits[i]);
            ps2_rise();
        end
        ps2_fall(bits[10]);
        check("pre_ready", kb_ready, m_q.size() > 0);
        check("pre_rdata", kb_rdata, m_head());
        valid     = bits[10] && (!c_PAR_EN || (^{d, bits[9]}));
        sig_rd_kb = pop_at_stop;
        step(1);
        sig_rd_kb = 1'b0;
        if (pop_at_stop && m_q.size() > 0) void'(m_q.pop_front());
        if (valid) begin
            if (m_q.size() < c_DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
        check("frame_err", frame_err, !valid);
        check("ready", kb_ready, m_q.size() > 0);
        check("rdata", kb_rdata, m_head());
        check("overflow", overflow, m_ovf);
        step(1);
        check("ferr_width", frame_err, 0);
        step(3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        step(4);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_head"}, kb_rdata, m_head());
        sig_rd_kb = 1'b1;
        step(1);
        sig_rd_kb = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
        check({tag, "_ready"}, kb_ready, m_q.size() > 0);
        check({tag, "_rdata"}, kb_rdata, m_head());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial;
        partial = 8'hA5;

        // Reset state
        step(3);
        rst_n = 1'b1;
        step(1);
        check("rst_ready", kb_ready, 0);
        check("rst_rdata", kb_rdata, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);

        // Single good frame, then pop
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("1c_value", kb_rdata, 8'h1C);
        pop_check("pop_1c");

        // Bad parity: rejected only with parity checking enabled
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        if (m_q.size() > 0) pop_check("pop_badpar");

        // Bad stop bit, then a good frame with a pop on an empty FIFO
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        check("33_value", kb_rdata, 8'h33);
        pop_check("pop_33");

        // Overflow: nine frames into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_order", kb_rdata, i);
            pop_check("pop_ovf");
        end
        check("ovf_empty", kb_ready, 0);
        pop_check("pop_empty");

        // Reset mid-frame with ps2_clk low across reset release
        ps2_fall(1'b0);
        ps2_rise();
        for (int i = 0; i < 4; i++) begin
            ps2_fall(partial[i]);
            ps2_rise();
        end
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        step(1);
        rst_n = 1'b0;
        step(3);
        m_q.delete();
        m_ovf = 1'b0;
        rst_n = 1'b1;
        step(6);
        check("mid_ready", kb_ready, 0);
        check("mid_rdata", kb_rdata, 0);
        check("mid_ovf", overflow, 0);
        check("mid_ferr", frame_err, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        step(4);
        send_frame(8'h2A, 1'b0, 1'b0, 1'b0);
        check("2a_value", kb_rdata, 8'h2A);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 7; i++) send_frame(8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        check("full_ovf", overflow, 0);
        for (int i = 0; i < 7; i++) pop_check("pop_full");
        check("tail_55", kb_rdata, 8'h55);
        pop_check("pop_55");

        // Random traffic
        for (int n = 0; n < 30; n++) begin
            send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) == 0);
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_check("pop_rnd");
        end
        while (m_q.size() > 0) pop_check("pop_drain");
        check("end_ready", kb_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
